// File: rtl/mvm_stream_sched.sv
// mvm_stream_sched
// Shares one 3x3 matrix-vector multiplier between two vector requesters.
// One vector is issued per 4-cycle multiplier slot (grant while mvm_row==2,
// strobe while mvm_row==3). A fixed-length tag line follows every issued
// vector through the multiplier latency, so each result is written into the
// output FIFO of the requester that issued it. Requesters are admitted only
// when their FIFO has credit for every result already in flight, so the
// multiplier never has to stall.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   r0_* / r1_*             vector requesters (valid/ready, {z,y,x} half words)
//   o0_* / o1_*             result FIFOs (valid/ready, {z,y,x})
//   cfg_we/addr/data/busy   matrix word writes (addr 0..8 -> m1..m9)
//   mvm_row                 slot phase from the multiplier
//   mvm_start, mvm_vec      registered issue strobe and operand vector
//   mvm_m                   {m9..m1} matrix register
//   mvm_res                 {dz,dy,dx} result from the multiplier
module mvm_stream_sched #(
    parameter int LAT   = 9,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_valid,
    input  logic [47:0]   r0_vec,
    output logic          r0_ready,
    input  logic          r1_valid,
    input  logic [47:0]   r1_vec,
    output logic          r1_ready,
    output logic          o0_valid,
    output logic [47:0]   o0_vec,
    input  logic          o0_ready,
    output logic          o1_valid,
    output logic [47:0]   o1_vec,
    input  logic          o1_ready,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [15:0]   cfg_data,
    output logic          cfg_busy,
    input  logic [1:0]    mvm_row,
    output logic          mvm_start,
    output logic [47:0]   mvm_vec,
    output logic [143:0]  mvm_m,
    input  logic [47:0]   mvm_res
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = 8;  // holds FIFO occupancy plus every in-flight tag

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]       state_reg, state_next;
    logic             rr_reg;          // requester favoured on a tie
    logic             mvm_start_reg;
    logic [47:0]      mvm_vec_reg;
    // Bit 0 is loaded on the grant edge, so bit LAT is valid in the cycle
    // the multiplier presents that vector's result.
    logic [LAT:0]     tag_valid_reg;
    logic [LAT:0]     tag_id_reg;

    logic [1:0]       req_valid, pop_req, eligible, fifo_valid;
    logic [1:0][47:0] req_vec, head_vec;
    logic             work_busy, slot, grant, grant_id, cfg_wr;

    assign req_valid = {r1_valid, r0_valid};
    assign req_vec   = {r1_vec, r0_vec};
    assign pop_req   = {o1_ready, o0_ready};

    // A strobe without its tag cannot happen, but both are checked so a
    // matrix write can never land while the multiplier reads mvm_m.
    assign work_busy = (|tag_valid_reg) | mvm_start_reg;
    assign cfg_wr    = (state_reg == ST_RUN) && cfg_we && !work_busy;
    assign cfg_busy  = (state_reg == ST_DRAIN) ||
                       ((state_reg == ST_RUN) && cfg_we && work_busy);

    // Any pending write blocks the slot: the write takes the edge and the
    // grant waits for the next slot.
    assign slot     = (mvm_row == 2'b10) && (state_reg == ST_RUN) && !cfg_we && !reset;
    assign grant    = slot && (|eligible);
    assign grant_id = (eligible == 2'b11) ? rr_reg : eligible[1];
    assign r0_ready = grant && !grant_id;
    assign r1_ready = grant && grant_id;

    assign mvm_start = mvm_start_reg;
    assign mvm_vec   = mvm_vec_reg;
    assign o0_valid  = fifo_valid[0];
    assign o1_valid  = fifo_valid[1];
    assign o0_vec    = head_vec[0];
    assign o1_vec    = head_vec[1];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:   if (cfg_we && work_busy) state_next = ST_DRAIN;
            ST_DRAIN: if (!work_busy)          state_next = ST_RUN;
            default:                           state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            rr_reg        <= 1'b0;
            mvm_start_reg <= 1'b0;
            mvm_vec_reg   <= '0;
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            mvm_start_reg <= grant;
            tag_valid_reg <= {tag_valid_reg[LAT-1:0], grant};
            tag_id_reg    <= {tag_id_reg[LAT-1:0], grant_id};
            if (grant) begin
                mvm_vec_reg <= req_vec[grant_id];
                rr_reg      <= ~grant_id;
            end
        end
    end

    genvar gi;

    // Per-requester result FIFO and credit check.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [47:0]   mem_reg [DEPTH];
            logic [AW:0]   wr_ptr_reg, rd_ptr_reg, occ;
            logic [CW-1:0] inflight, used;
            logic          cap, empty, pop;

            always_comb begin
                inflight = '0;
                for (int k = 0; k <= LAT; k++) begin
                    if (tag_valid_reg[k] && (tag_id_reg[k] == 1'(gi)))
                        inflight = inflight + CW'(1);
                end
            end

            assign occ   = wr_ptr_reg - rd_ptr_reg;
            assign used  = CW'(occ) + inflight;
            assign cap   = tag_valid_reg[LAT] && (tag_id_reg[LAT] == 1'(gi));
            assign empty = (occ == '0);
            assign pop   = pop_req[gi] && !empty;

            assign eligible[gi]   = req_valid[gi] && (used < CW'(DEPTH));
            assign fifo_valid[gi] = !empty;
            assign head_vec[gi]   = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];

            always_ff @(posedge clk) begin
                if (cap)
                    mem_reg[wr_ptr_reg[AW-1:0]] <= mvm_res;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (cap) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
                    if (pop) rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    // Matrix words m1..m9; addresses above 8 match no word.
    generate
        for (gi = 0; gi < 9; gi++) begin : g_mat
            logic [15:0] word_reg;

            always_ff @(posedge clk) begin
                if (reset)
                    word_reg <= '0;
                else if (cfg_wr && (cfg_addr == 4'(gi)))
                    word_reg <= cfg_data;
            end

            assign mvm_m[16*gi +: 16] = word_reg;
        end
    endgenerate

endmodule
